// File: rtl/mem_access_if.sv
// Data-bus interface between the MEM-stage access unit (master) and the memory system (slave).
interface mem_access_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: lane steering, request/grant/response sequencing,
// load extension, misalignment detection and a bounded-wait timeout.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  MEM_result,
    input  logic [31:0]  MEM_wdata,
    input  logic [2:0]   MEM_funct3,
    input  logic         MEM_rmem,
    input  logic         MEM_wmem,
    mem_access_if.master dbus,
    output logic [31:0]  MEM_mem_rdata,
    output logic         mem_stall,
    output logic         misalign,
    output logic         bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  byte_off;
    logic        is_half;
    logic        is_word;
    logic        access_req;
    logic        misaligned;
    logic        access_valid;
    logic        timed_out;
    logic [15:0] lane_data;
    logic [31:0] load_ext;

    always_comb begin
        byte_off     = MEM_result[1:0];
        is_half      = (MEM_funct3[1:0] == 2'b01);
        is_word      = MEM_funct3[1];
        access_req   = MEM_rmem | MEM_wmem;
        misaligned   = access_req & ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));
        access_valid = access_req & ~misaligned;
    end

    // Stores are replicated into every lane so the byte enables alone pick the target bytes.
    always_comb begin
        dbus.dbus_addr = {MEM_result[31:2], 2'b00};
        if (is_word) begin
            dbus.dbus_be    = 4'b1111;
            dbus.dbus_wdata = MEM_wdata;
        end else if (is_half) begin
            dbus.dbus_be    = 4'b0011 << byte_off;
            dbus.dbus_wdata = {2{MEM_wdata[15:0]}};
        end else begin
            dbus.dbus_be    = 4'b0001 << byte_off;
            dbus.dbus_wdata = {4{MEM_wdata[7:0]}};
        end
    end

    always_comb begin
        lane_data = 16'(dbus.dbus_rdata >> {byte_off, 3'b000});
        if (is_word) begin
            load_ext = dbus.dbus_rdata;
        end else if (is_half) begin
            load_ext = {{16{lane_data[15] & ~MEM_funct3[2]}}, lane_data};
        end else begin
            load_ext = {{24{lane_data[7] & ~MEM_funct3[2]}}, lane_data[7:0]};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        dbus.dbus_req = 1'b0;
        mem_stall     = 1'b0;
        bus_err       = 1'b0;
        timed_out     = (cnt_q == TIMEOUT_CNT);

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                rdata_d = '0;
                if (access_valid) begin
                    dbus.dbus_req = 1'b1;
                    mem_stall     = 1'b1;
                    state_d       = dbus.dbus_gnt ? WAIT : REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (timed_out) begin
                    bus_err = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    dbus.dbus_req = 1'b1;
                    if (dbus.dbus_gnt) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (timed_out) begin
                    bus_err = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else if (dbus.dbus_rvalid) begin
                    // A store acknowledge carries no load result, so nothing is latched for it.
                    rdata_d = MEM_rmem ? load_ext : '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rstn) begin
            dbus.dbus_req = 1'b0;
            mem_stall     = 1'b0;
            bus_err       = 1'b0;
        end
    end

    always_comb begin
        dbus.dbus_we  = dbus.dbus_req & MEM_wmem & ~MEM_rmem;
        misalign      = misaligned & (state_q == IDLE) & ~rstn;
        MEM_mem_rdata = ((state_q == DONE) && !rstn) ? rdata_q : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a per-transaction timeline model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_mem_access;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] MEM_result;
    logic [31:0] MEM_wdata;
    logic [2:0]  MEM_funct3;
    logic        MEM_rmem;
    logic        MEM_wmem;
    logic [31:0] MEM_mem_rdata;
    logic        mem_stall;
    logic        misalign;
    logic        bus_err;

    mem_access_if dbus ();

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .MEM_result    (MEM_result),
        .MEM_wdata     (MEM_wdata),
        .MEM_funct3    (MEM_funct3),
        .MEM_rmem      (MEM_rmem),
        .MEM_wmem      (MEM_wmem),
        .dbus          (dbus),
        .MEM_mem_rdata (MEM_mem_rdata),
        .mem_stall     (mem_stall),
        .misalign      (misalign),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction currently being modelled
    logic        modelActive = 1'b0;
    int          curK;
    logic [31:0] tAddr, tWdata, tRdata;
    logic [2:0]  tF3;
    logic        tRmem, tWmem;
    int          tGnt, tRv;

    // Observations of the last transaction, pinned against literals
    int          stallCount, reqCount, errCount, misCount, errK;
    logic [31:0] doneRdata, lastWdata;
    logic [3:0]  lastBe;
    logic        lastWe;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sizeBytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit isMisaligned(input logic [31:0] addr, input logic [2:0] f3);
        int n = sizeBytes(f3);
        return (n > 1) && ((int'(addr[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] modelBe(input logic [31:0] addr, input logic [2:0] f3);
        int n = sizeBytes(f3);
        int off = (n == 4) ? 0 : int'(addr[1:0]);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < n; i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] wdata, input logic [2:0] f3);
        int n = sizeBytes(f3);
        logic [31:0] res;
        for (int lane = 0; lane < 4; lane++) res[8*lane +: 8] = wdata[8*(lane % n) +: 8];
        return res;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] f3);
        int n = sizeBytes(f3);
        int off = (n == 4) ? 0 : int'(addr[1:0]);
        longint v;
        v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // f: last stalled cycle, d: result cycle (index within the transaction, request cycle = 0)
    function automatic void modelTimeline(input logic [31:0] addr, input logic [2:0] f3,
                                          input int gntAt, input int rvAfter,
                                          output bit mis, output bit timedOut,
                                          output int g, output int f, output int d);
        int r;
        mis = isMisaligned(addr, f3);
        g   = gntAt;
        if (mis) begin
            timedOut = 1'b0;
            f = -1;
            d = 0;
        end else begin
            r        = (gntAt >= 0 && rvAfter >= 0) ? gntAt + rvAfter : 1000;
            timedOut = (r > TIMEOUT);
            f        = timedOut ? TIMEOUT + 1 : r;
            d        = f + 1;
        end
    endfunction

    always @(negedge clk) begin
        if (modelActive) begin
            bit mis, timedOut;
            int g, f, d, k;
            logic expReq, expStall, expErr, expMis;
            logic [31:0] expRd;
            k = curK;
            modelTimeline(tAddr, tF3, tGnt, tRv, mis, timedOut, g, f, d);
            expMis   = mis && (k == 0);
            expStall = !mis && (k <= f);
            expReq   = !mis && (k <= f) && (g < 0 || k <= g) && !(timedOut && k == f);
            expErr   = timedOut && (k == f);
            expRd    = (k == d && !mis && !timedOut && tRmem) ? modelLoad(tRdata, tAddr, tF3) : 32'd0;

            checkOutput("mem_stall", 32'(mem_stall), 32'(expStall));
            checkOutput("dbus_req", 32'(dbus.dbus_req), 32'(expReq));
            checkOutput("bus_err", 32'(bus_err), 32'(expErr));
            checkOutput("misalign", 32'(misalign), 32'(expMis));
            checkOutput("MEM_mem_rdata", MEM_mem_rdata, expRd);
            if (expReq) begin
                checkOutput("dbus_addr", dbus.dbus_addr, {tAddr[31:2], 2'b00});
                checkOutput("dbus_be", 32'(dbus.dbus_be), 32'(modelBe(tAddr, tF3)));
                checkOutput("dbus_wdata", dbus.dbus_wdata, modelWdata(tWdata, tF3));
                checkOutput("dbus_we", 32'(dbus.dbus_we), 32'(tWmem && !tRmem));
            end

            if (mem_stall) stallCount++;
            if (misalign) misCount++;
            if (bus_err) begin
                errCount++;
                errK = k;
            end
            if (dbus.dbus_req) begin
                reqCount++;
                lastBe    = dbus.dbus_be;
                lastWdata = dbus.dbus_wdata;
                lastWe    = dbus.dbus_we;
            end
            if (k == d) doneRdata = MEM_mem_rdata;
        end
    end

    // gntAt: cycle index of the grant (-1 = never); rvAfter: cycles from grant to response (-1 = never)
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic rmem, input logic wmem,
                                 input int gntAt, input int rvAfter, input logic [31:0] rdata);
        bit mis, timedOut;
        int g, f, d;
        modelTimeline(addr, f3, gntAt, rvAfter, mis, timedOut, g, f, d);
        tAddr = addr; tWdata = wdata; tF3 = f3; tRmem = rmem; tWmem = wmem;
        tGnt = gntAt; tRv = rvAfter; tRdata = rdata;
        stallCount = 0; reqCount = 0; errCount = 0; misCount = 0; errK = -1;
        doneRdata = 32'hFFFF_FFFF; lastBe = 4'b0000; lastWdata = 32'd0; lastWe = 1'b0;
        MEM_result = addr; MEM_wdata = wdata; MEM_funct3 = f3; MEM_rmem = rmem; MEM_wmem = wmem;
        for (int k = 0; k <= d; k++) begin
            curK = k;
            modelActive = 1'b1;
            // In the result cycle the bus also raises spurious gnt/rvalid, which must be ignored.
            dbus.dbus_gnt    = (k == gntAt) || (k == d && d > 0);
            dbus.dbus_rvalid = (gntAt >= 0 && rvAfter >= 0 && k == gntAt + rvAfter) || (k == d && d > 0);
            dbus.dbus_rdata  = (gntAt >= 0 && rvAfter >= 0 && k == gntAt + rvAfter) ? rdata : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
        end
        modelActive      = 1'b0;
        dbus.dbus_gnt    = 1'b0;
        dbus.dbus_rvalid = 1'b0;
        MEM_rmem         = 1'b0;
        MEM_wmem         = 1'b0;
    endtask

    initial begin
        rstn = 1'b1;
        MEM_result = 32'd0; MEM_wdata = 32'd0; MEM_funct3 = 3'b010; MEM_rmem = 1'b0; MEM_wmem = 1'b0;
        dbus.dbus_gnt = 1'b0; dbus.dbus_rvalid = 1'b0; dbus.dbus_rdata = 32'd0;
        @(posedge clk);
        #1;

        // Under reset a misaligned access must not flag and a valid one must not request
        MEM_result = 32'h6; MEM_funct3 = 3'b010; MEM_rmem = 1'b1;
        @(negedge clk);
        checkOutput("rst_misalign", 32'(misalign), 32'd0);
        checkOutput("rst_stall_mis", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        MEM_result = 32'h103; MEM_funct3 = 3'b000;
        dbus.dbus_gnt = 1'b1;
        @(negedge clk);
        checkOutput("rst_req", 32'(dbus.dbus_req), 32'd0);
        checkOutput("rst_stall", 32'(mem_stall), 32'd0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0; MEM_rmem = 1'b0; dbus.dbus_gnt = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_rdata", MEM_mem_rdata, 32'd0);
        checkOutput("post_rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;

        // LB 0x103, immediate grant, response two cycles later
        applyStimulus(32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 0, 2, 32'h80FF_FFFF);
        checkOutput("lb_rdata_lit", doneRdata, 32'hFFFF_FF80);
        checkOutput("lb_stall_cycles", 32'(stallCount), 32'd3);
        checkOutput("lb_be_lit", 32'(lastBe), 32'b1000);

        // SH 0x202, grant three cycles late
        applyStimulus(32'h202, 32'h0000_ABCD, 3'b001, 1'b0, 1'b1, 3, 1, 32'h0);
        checkOutput("sh_req_cycles", 32'(reqCount), 32'd4);
        checkOutput("sh_be_lit", 32'(lastBe), 32'b1100);
        checkOutput("sh_wdata_lit", lastWdata, 32'hABCD_ABCD);
        checkOutput("sh_we_lit", 32'(lastWe), 32'd1);

        // LW 0x6 misaligned
        applyStimulus(32'h6, 32'h0, 3'b010, 1'b1, 1'b0, 0, 1, 32'h0);
        checkOutput("lw_mis_count", 32'(misCount), 32'd1);
        checkOutput("lw_mis_req", 32'(reqCount), 32'd0);
        checkOutput("lw_mis_stall", 32'(stallCount), 32'd0);

        // LHU 0x10, grant never arrives
        applyStimulus(32'h10, 32'h0, 3'b101, 1'b1, 1'b0, -1, -1, 32'h0);
        checkOutput("to_err_count", 32'(errCount), 32'd1);
        checkOutput("to_err_cycle", 32'(errK), 32'd5);
        checkOutput("to_stall_cycles", 32'(stallCount), 32'd6);
        checkOutput("to_rdata_lit", doneRdata, 32'd0);

        // Timeout while waiting for the response
        applyStimulus(32'h40, 32'h0, 3'b010, 1'b1, 1'b0, 0, -1, 32'h0);
        checkOutput("to_wait_err", 32'(errCount), 32'd1);

        applyStimulus(32'h2, 32'h0, 3'b001, 1'b1, 1'b0, 0, 1, 32'h8001_0000);
        checkOutput("lh_rdata_lit", doneRdata, 32'hFFFF_8001);
        applyStimulus(32'h101, 32'h0, 3'b100, 1'b1, 1'b0, 2, 2, 32'h0000_9A00);
        checkOutput("lbu_rdata_lit", doneRdata, 32'h0000_009A);
        applyStimulus(32'h3, 32'h0000_005A, 3'b000, 1'b0, 1'b1, 0, 1, 32'h0);
        applyStimulus(32'h8, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 1, 1, 32'h0);
        applyStimulus(32'h1, 32'h0000_1111, 3'b001, 1'b0, 1'b1, 0, 1, 32'h0);

        // Load and store both set: behaves as a load
        applyStimulus(32'h0, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b1, 0, 1, 32'h0000_7FFE);
        checkOutput("ldst_we", 32'(lastWe), 32'd0);
        checkOutput("ldst_rdata", doneRdata, 32'h0000_7FFE);

        // Back-to-back loads
        applyStimulus(32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 1, 1, 32'h1234_5678);
        applyStimulus(32'h104, 32'h0, 3'b010, 1'b1, 1'b0, 0, 1, 32'hCAFE_F00D);
        checkOutput("b2b_second_rdata", doneRdata, 32'hCAFE_F00D);

        // Reset while in WAIT, response arrives the next cycle
        MEM_result = 32'h103; MEM_funct3 = 3'b000; MEM_rmem = 1'b1; MEM_wmem = 1'b0;
        dbus.dbus_gnt = 1'b1;
        @(negedge clk);
        checkOutput("rw_req", 32'(dbus.dbus_req), 32'd1);
        @(posedge clk);
        #1;
        dbus.dbus_gnt = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rw_stall_in_rst", 32'(mem_stall), 32'd0);
        checkOutput("rw_req_in_rst", 32'(dbus.dbus_req), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b0; MEM_rmem = 1'b0;
        dbus.dbus_rvalid = 1'b1; dbus.dbus_rdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("rw_late_stall", 32'(mem_stall), 32'd0);
        checkOutput("rw_late_rdata", MEM_mem_rdata, 32'd0);
        checkOutput("rw_late_req", 32'(dbus.dbus_req), 32'd0);
        @(posedge clk);
        #1;
        dbus.dbus_rvalid = 1'b0;
        @(negedge clk);
        checkOutput("rw_after_rdata", MEM_mem_rdata, 32'd0);
        checkOutput("rw_after_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(32'h20, 32'h0, 3'b000, 1'b1, 1'b0, 0, 1, 32'h0000_0081);
        checkOutput("post_rw_rdata", doneRdata, 32'hFFFF_FF81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
